// File: rtl/divider.sv
// Purpose: sequential 32-bit DIV/DIVU (radix-2 restoring on magnitudes, sign fix-up), HI/LO packed result.
// Latency: 34 cycles from div_en cycle to the div_valid pulse; one quotient bit per cycle.
// Backpressure: div_busy stalls the pipeline; div_en is ignored unless idle, flush aborts without a result.
module divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        div_en,
  input  logic [31:0] div_A,
  input  logic [31:0] div_B,
  input  logic        is_unsign,
  output logic        div_busy,
  output logic        div_valid,
  output logic [63:0] div_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] a_raw_q, a_raw_d;
  logic        sign_q_q, sign_q_d;
  logic        sign_r_q, sign_r_d;
  logic        dz_q, dz_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [63:0] out_q, out_d;

  // Operand magnitudes: only signed operands with the MSB set are negated.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  assign a_neg = ~is_unsign & div_A[31];
  assign b_neg = ~is_unsign & div_B[31];
  assign a_mag = a_neg ? (32'd0 - div_A) : div_A;
  assign b_mag = b_neg ? (32'd0 - div_B) : div_B;

  // One restoring step: shifted partial remainder minus divisor; bit 32 set means it did not fit.
  logic [32:0] trial;
  assign trial = {1'b0, rem_q[30:0], quo_q[31]} - {1'b0, dvs_q};

  // Signed fix-up of the final magnitudes.
  logic [31:0] quo_fix, rem_fix;
  assign quo_fix = sign_q_q ? (32'd0 - quo_q) : quo_q;
  assign rem_fix = sign_r_q ? (32'd0 - rem_q) : rem_q;

  // State and datapath registers; reset returns every output to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      dvs_q    <= 32'd0;
      a_raw_q  <= 32'd0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      out_q    <= 64'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      a_raw_q  <= a_raw_d;
      sign_q_q <= sign_q_d;
      sign_r_q <= sign_r_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      out_q    <= out_d;
    end
  end

  // Next-state logic: accept in IDLE, 32 restoring steps in DIV, publish in FIX; flush overrides all.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    a_raw_d  = a_raw_q;
    sign_q_d = sign_q_q;
    sign_r_d = sign_r_q;
    dz_d     = dz_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    out_d    = out_q;

    if (flush) begin
      // Abort: no result, div_out keeps its previous value.
      state_d = S_IDLE;
      cnt_d   = 6'd0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (div_en) begin
            rem_d    = 32'd0;
            quo_d    = a_mag;
            dvs_d    = b_mag;
            a_raw_d  = div_A;
            sign_q_d = ~is_unsign & (div_A[31] ^ div_B[31]);
            sign_r_d = ~is_unsign & div_A[31];
            dz_d     = (div_B == 32'd0);
            cnt_d    = 6'd0;
            busy_d   = 1'b1;
            state_d  = S_DIV;
          end
        end
        S_DIV: begin
          if (!trial[32]) begin
            rem_d = trial[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = {rem_q[30:0], quo_q[31]};
            quo_d = {quo_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d = S_FIX;
          end
        end
        S_FIX: begin
          // Divide-by-zero returns the raw dividend in HI and all-ones in LO regardless of signedness.
          out_d   = dz_q ? {a_raw_q, 32'hFFFF_FFFF} : {rem_fix, quo_fix};
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign div_busy  = busy_q;
  assign div_valid = valid_q;
  assign div_out   = out_q;

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider: hand-computed DIV/DIVU results, latency, busy width, flush and reset.
// All outputs sampled on the falling edge; inputs driven on the falling edge.
module tb_divider;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        div_en;
  logic [31:0] div_A;
  logic [31:0] div_B;
  logic        is_unsign;
  logic        div_busy;
  logic        div_valid;
  logic [63:0] div_out;

  int errors = 0;
  int checks = 0;

  divider dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .div_en    (div_en),
    .div_A     (div_A),
    .div_B     (div_B),
    .is_unsign (is_unsign),
    .div_busy  (div_busy),
    .div_valid (div_valid),
    .div_out   (div_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts one operation at the current falling edge and follows it to div_valid.
  // With noise set, div_en is pulsed with other operands while the operation is busy.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic u, input logic [63:0] exp, input bit noise);
    int lat;
    int busy_n;
    div_A     = a;
    div_B     = b;
    is_unsign = u;
    div_en    = 1'b1;
    #1;
    check({tag, "_busy_pre"}, {63'd0, div_busy}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    div_en = 1'b0;
    div_A  = $urandom;
    div_B  = $urandom;
    lat    = 0;
    busy_n = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) @(negedge clk);
      if (div_busy) busy_n++;
      if (div_valid) begin
        lat = n;
        break;
      end
      if (noise) begin
        div_en    = (n == 5 || n == 20);
        div_A     = 32'd1;
        div_B     = 32'd1;
        is_unsign = ~u;
      end
    end
    div_en = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'd34);
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'd33);
    check({tag, "_out"}, div_out, exp);
  endtask

  initial begin
    logic seen;
    rst       = 1'b1;
    flush     = 1'b0;
    div_en    = 1'b0;
    div_A     = 32'd0;
    div_B     = 32'd0;
    is_unsign = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy",  {63'd0, div_busy},  64'd0);
    check("rst_valid", {63'd0, div_valid}, 64'd0);
    check("rst_out",   div_out,            64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Arithmetic vectors, issued back to back in each previous valid cycle.
    run_op("divu_100_7",   32'd100,         32'd7,           1'b1, 64'h0000_0002_0000_000E, 1'b0);
    run_op("div_m7_2",     32'hFFFF_FFF9,   32'h2,           1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    run_op("div_7_m2",     32'h7,           32'hFFFF_FFFE,   1'b0, 64'h0000_0001_FFFF_FFFD, 1'b0);
    run_op("divu_ff_2",    32'hFFFF_FFFF,   32'h2,           1'b1, 64'h0000_0001_7FFF_FFFF, 1'b0);
    run_op("div_ff_2",     32'hFFFF_FFFF,   32'h2,           1'b0, 64'hFFFF_FFFF_0000_0000, 1'b0);
    run_op("divu_by0",     32'h1234_5678,   32'h0,           1'b1, 64'h1234_5678_FFFF_FFFF, 1'b0);
    run_op("div_by0",      32'h1234_5678,   32'h0,           1'b0, 64'h1234_5678_FFFF_FFFF, 1'b0);
    run_op("div_ovf",      32'h8000_0000,   32'hFFFF_FFFF,   1'b0, 64'h0000_0000_8000_0000, 1'b0);

    // Flush at E10: no result, busy drops, div_out retained.
    div_A = 32'd100; div_B = 32'd7; is_unsign = 1'b1; div_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    div_en = 1'b0;
    seen   = div_valid;
    repeat (9) begin
      @(negedge clk);
      seen = seen | div_valid;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    seen  = seen | div_valid;
    check("flush_busy",  {63'd0, div_busy}, 64'd0);
    check("flush_valid", {63'd0, seen},     64'd0);
    check("flush_out",   div_out,           64'h0000_0000_8000_0000);
    run_op("divu_9_3_after_flush", 32'd9, 32'd3, 1'b1, 64'h0000_0000_0000_0003, 1'b0);

    // Flush and div_en in the same idle cycle: nothing is accepted.
    @(negedge clk);
    div_A = 32'd5; div_B = 32'd1; is_unsign = 1'b1; div_en = 1'b1; flush = 1'b1;
    @(negedge clk);
    div_en = 1'b0; flush = 1'b0;
    check("flush_en_busy", {63'd0, div_busy}, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | div_valid | div_busy;
    end
    check("flush_en_quiet", {63'd0, seen}, 64'd0);
    check("flush_en_out",   div_out,       64'h0000_0000_0000_0003);

    // div_en pulses while busy are ignored; result arrives on schedule.
    run_op("divu_100_7_noise", 32'd100, 32'd7, 1'b1, 64'h0000_0002_0000_000E, 1'b1);

    // Reset at E20 of an operation: outputs clear immediately, no result follows.
    @(negedge clk);
    div_A = 32'hFFFF_FFF9; div_B = 32'd2; is_unsign = 1'b0; div_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    div_en = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy",  {63'd0, div_busy},  64'd0);
    check("mid_rst_valid", {63'd0, div_valid}, 64'd0);
    check("mid_rst_out",   div_out,            64'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | div_valid;
    end
    check("mid_rst_no_valid", {63'd0, seen}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/divider.md
# divider

Sequential 32-bit integer divider for the EX-stage HI/LO unit, the inverse counterpart of the Booth/Wallace multiplier. It executes MIPS DIV/DIVU by radix-2 restoring division on operand magnitudes with a final sign fix-up. It raises a busy flag so the pipeline can stall, and delivers a 64-bit {remainder, quotient} word in the same HI/LO packing the multiplier uses. Results are cancelled by a pipeline flush.

## Interface
- No parameters; datapath fixed at 32-bit operands and 64-bit result.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  pipeline flush; aborts any operation in progress.
- div_en  in  1  start request; sampled only in IDLE.
- div_A  in  32  dividend.
- div_B  in  32  divisor.
- is_unsign  in  1  1 = DIVU, 0 = DIV (two's complement).
- div_busy  out  1  high while an accepted operation is in flight.
- div_valid  out  1  one-cycle pulse: div_out updated this cycle.
- div_out  out  64  {remainder[63:32] (HI), quotient[31:0] (LO)}.

## Operation
- States: IDLE, DIV, FIX.
- IDLE: if div_en=1 and flush=0, accept.
  - Latch |div_A| and |div_B|. Magnitudes apply only when is_unsign=0 and the MSB is set; unsigned operands are taken raw.
  - Latch sign_q = A[31]^B[31] and sign_r = A[31], both forced to 0 when unsigned.
  - Latch div_zero = (div_B==0) and the raw div_A.
  - Clear the 6-bit counter and go to DIV.
- DIV: one restoring step per cycle on working register {rem[31:0], quo[31:0]}.
  - trial[32:0] = {1'b0, rem[30:0], quo[31]} − {1'b0, divisor}.
  - If trial[32]==0: rem ← trial[31:0], shift 1 into quo LSB.
  - Else: rem ← {rem[30:0], quo[31]}, shift 0 into quo LSB.
  - Counter increments each step; after the 32nd step go to FIX.
- FIX: write div_out, pulse div_valid, go to IDLE.
  - Quotient = sign_q ? −quo : quo; remainder = sign_r ? −rem : rem.
  - Divide-by-zero overrides this: div_out = {raw div_A, 32'hFFFF_FFFF}, independent of is_unsign.
- Overflow case 0x8000_0000 / 0xFFFF_FFFF signed: quotient wraps to 0x8000_0000, remainder 0. No exception is raised.
- div_en while not IDLE: ignored. The operation in flight is unaffected.
- flush in any state: next state IDLE, counter cleared, no div_valid pulse, div_out retains its previous value.
- flush and div_en in the same IDLE cycle: flush wins, nothing accepted.
- div_out holds its last result until the next FIX. Operand inputs need not be held after acceptance.

## Timing
- Reset (asynchronous): state IDLE, div_busy=0, div_valid=0, div_out=64'h0, counter 0, working regs 0.
- Call the accepting edge E0.
- div_busy is registered: high from after E0 through the cycle ending at E33 (33 cycles). It is low in the cycle div_en is first presented; the stall logic ORs div_en with div_busy.
- DIV steps occur at edges E1..E32. FIX executes at E33.
- After E33: div_out is valid, div_valid=1 for exactly one cycle, and div_busy=0.
- Latency is 34 cycles from the div_en cycle to the div_valid cycle.
- Back-to-back: div_en asserted in the div_valid cycle is accepted (state is IDLE).
- Flush at edge Ek (E1≤k≤E33): div_busy=0 after Ek. A new div_en is accepted at the following edge.
- rst asserted mid-operation: immediate return to reset values, no div_valid.

## Test plan
- DIVU 100/7, div_en for one cycle → div_valid exactly 34 cycles later with div_out=64'h0000_0002_0000_000E; div_busy high 33 cycles.
- DIV −7/2 (0xFFFF_FFF9, 0x2) → div_out=64'hFFFF_FFFF_FFFF_FFFD. DIV 7/−2 → 64'h0000_0001_FFFF_FFFD.
- 0xFFFF_FFFF/2: DIVU → 64'h0000_0001_7FFF_FFFF; DIV → 64'hFFFF_FFFF_0000_0000.
- Divide by zero 0x1234_5678/0, both signednesses → 64'h1234_5678_FFFF_FFFF. DIV 0x8000_0000/0xFFFF_FFFF → 64'h0000_0000_8000_0000.
- Accept 100/7, flush at E10 → no div_valid, busy low after E10, div_out unchanged. Issue DIVU 9/3 next cycle → 64'h0000_0000_0000_0003 after 34 cycles. Flush+div_en same cycle → no accept.
- Assert rst at E20 of an operation → all outputs 0 immediately. div_en pulses during busy are ignored, and the original result still arrives at the scheduled cycle.
